// File: rtl/tdc_meas_sequencer_if.sv
// Host-side bundle for the TDC measurement sequencer: burst control, delay-line
// strobes, tap code input and the averaged result handshake.
interface tdc_meas_sequencer_if #(
    parameter int TAPS = 32,
    parameter int CW   = $clog2(TAPS + 1)
);
    logic            start;
    logic            abort;
    logic            launch;
    logic            capture;
    logic [TAPS-1:0] therm;
    logic [CW-1:0]   result;
    logic            res_valid;
    logic            res_ready;
    logic            bubble;
    logic            ovf;
    logic            busy;

    modport master (
        output start, abort, therm, res_ready,
        input  launch, capture, result, res_valid, bubble, ovf, busy
    );

    modport slave (
        input  start, abort, therm, res_ready,
        output launch, capture, result, res_valid, bubble, ovf, busy
    );
endinterface

// File: rtl/tdc_meas_sequencer.sv
// Delay-line TDC sequencer: launches, captures and popcount-encodes 2^AVG_LOG2
// samples per request and returns their truncated average with sticky flags.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// LAUNCH  | launch pulse into the delay line
// WAIT    | SETTLE cycles for the edge to propagate
// CAPTURE | capture strobe, therm latched into samp at the closing edge
// ENCODE  | popcount samp, accumulate, update bubble/ovf working flags
// DONE    | result presented, waiting for res_ready
module tdc_meas_sequencer #(
    parameter int TAPS     = 32,
    parameter int AVG_LOG2 = 2,
    parameter int SETTLE   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    tdc_meas_sequencer_if.slave   bus
);
    localparam int CW  = $clog2(TAPS + 1);
    localparam int AW  = CW + AVG_LOG2;
    localparam int WCW = $clog2(SETTLE + 1);
    localparam int SCW = AVG_LOG2 + 1;
    localparam logic [SCW-1:0] N_SMP = SCW'(1 << AVG_LOG2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        ENCODE  = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t          state;
    logic [TAPS-1:0] samp;
    logic [AW-1:0]   acc;
    logic [SCW-1:0]  smp_cnt;
    logic [WCW-1:0]  wait_cnt;
    logic            bub_w;
    logic            ovf_w;

    logic [CW-1:0]   code;
    logic [AW-1:0]   acc_sum;
    logic [SCW-1:0]  smp_nxt;
    logic            bub_hit;
    logic            ovf_hit;

    // Popcount rather than priority-encode so a bubble still yields a sane count.
    always_comb begin
        code = '0;
        for (int i = 0; i < TAPS; i++) begin
            code = code + CW'(samp[i]);
        end
        acc_sum = acc + AW'(code);
        smp_nxt = smp_cnt + SCW'(1);
        bub_hit = (samp & (samp + TAPS'(1))) != '0;
        ovf_hit = &samp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            samp          <= '0;
            acc           <= '0;
            smp_cnt       <= '0;
            wait_cnt      <= '0;
            bub_w         <= 1'b0;
            ovf_w         <= 1'b0;
            bus.launch    <= 1'b0;
            bus.capture   <= 1'b0;
            bus.result    <= '0;
            bus.res_valid <= 1'b0;
            bus.bubble    <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.busy      <= 1'b0;
        end else if (bus.abort && (state inside {LAUNCH, WAIT, CAPTURE, ENCODE})) begin
            // Partial burst is dropped; delivered result and flags are left alone.
            state       <= IDLE;
            bus.launch  <= 1'b0;
            bus.capture <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= LAUNCH;
                        bus.launch <= 1'b1;
                        bus.busy   <= 1'b1;
                        acc        <= '0;
                        smp_cnt    <= '0;
                        bub_w      <= 1'b0;
                        ovf_w      <= 1'b0;
                    end
                end
                LAUNCH: begin
                    state      <= WAIT;
                    bus.launch <= 1'b0;
                    wait_cnt   <= WCW'(SETTLE - 1);
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state       <= CAPTURE;
                        bus.capture <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end
                CAPTURE: begin
                    state       <= ENCODE;
                    bus.capture <= 1'b0;
                    samp        <= bus.therm;
                end
                ENCODE: begin
                    acc     <= acc_sum;
                    smp_cnt <= smp_nxt;
                    bub_w   <= bub_w | bub_hit;
                    ovf_w   <= ovf_w | ovf_hit;
                    if (smp_nxt == N_SMP) begin
                        state         <= DONE;
                        bus.result    <= CW'(acc_sum >> AVG_LOG2);
                        bus.bubble    <= bub_w | bub_hit;
                        bus.ovf       <= ovf_w | ovf_hit;
                        bus.res_valid <= 1'b1;
                    end else begin
                        state      <= LAUNCH;
                        bus.launch <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        state         <= IDLE;
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/tdc_meas_sequencer.md
# tdc_meas_sequencer

Measurement sequencer for the delay-line TDC inside the TT tile. It issues launch pulses into the delay line and capture strobes to the tap registers, and encodes each sampled thermometer code into a binary tap count. It averages 2^AVG_LOG2 samples per request and returns the result to the host-side register/IO logic over a valid/ready handshake, together with sticky bubble and overflow flags.

## Interface

- TAPS, 32: delay-line taps (thermometer width), 8..64.
- AVG_LOG2, 2: log2 of samples per burst, 0..4.
- SETTLE, 3: cycles spent in WAIT between launch and capture, ≥1.
- Derived: CW = clog2(TAPS+1); AW = CW + AVG_LOG2.

Ports:

- clk  in  1  single system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  burst request, level; sampled only in IDLE.
- abort  in  1  cancel the in-flight burst; effective in LAUNCH/WAIT/CAPTURE/ENCODE only.
- launch  out  1  one-cycle pulse to the delay-line start input.
- capture  out  1  one-cycle strobe freezing the tap registers.
- therm  in  TAPS  tap thermometer code, LSB = first tap.
- result  out  CW  averaged tap count.
- res_valid  out  1  result/flags valid.
- res_ready  in  1  consumer accepts result.
- bubble  out  1  sticky: some sample in the burst was non-monotonic.
- ovf  out  1  sticky: some sample in the burst was all ones.
- busy  out  1  high in every state except IDLE.

## Operation

- FSM states: IDLE, LAUNCH, WAIT, CAPTURE, ENCODE, DONE.
- IDLE: if start=1, go to LAUNCH. On entry to LAUNCH, clear acc, the sample counter, and the bubble/ovf working flags.
- LAUNCH: launch=1 for exactly this cycle, then go to WAIT.
- WAIT: count SETTLE cycles, then go to CAPTURE.
- CAPTURE: capture=1 for this cycle. therm is registered into samp at the edge ending this cycle, then go to ENCODE.
- ENCODE:
  - code = popcount(samp), range 0..TAPS, which tolerates bubbles.
  - acc += code; acc is AW bits wide and cannot overflow.
  - Bubble condition: (samp & (samp+1)) != 0. OR it into the working bubble flag.
  - Overflow condition: samp is all ones. OR it into the working ovf flag.
  - Increment the sample counter. If it now equals 2^AVG_LOG2, go to DONE; otherwise go to LAUNCH.
- On entry to DONE:
  - result = acc >> AVG_LOG2 (truncating).
  - bubble and ovf outputs take the working flags.
  - res_valid goes high.
- DONE: hold res_valid, result, bubble and ovf stable until res_valid & res_ready. On that edge, clear res_valid and go to IDLE. abort is ignored in DONE.
- abort, in LAUNCH/WAIT/CAPTURE/ENCODE: go to IDLE at the next edge.
  - The partial acc is discarded and no res_valid is produced.
  - launch and capture are low from that edge on.
  - result, bubble and ovf keep their last delivered values.
- abort and start are both sampled every cycle; abort has priority, so start has no effect until IDLE is reached.
- AVG_LOG2=0: a single sample; result = code.

## Timing

- Reset values: launch=0, capture=0, res_valid=0, result=0, bubble=0, ovf=0, busy=0, state=IDLE.
- Reset is asynchronous; asserting it mid-burst forces IDLE and all outputs to the reset values immediately.
- Edge E0 samples start=1 in IDLE. Cycle after E0: launch=1, busy=1.
- Per-sample period: SETTLE+3 cycles (LAUNCH 1, WAIT SETTLE, CAPTURE 1, ENCODE 1).
- launch-to-capture spacing: SETTLE+1 cycles.
- res_valid rises at edge E0 + 2^AVG_LOG2·(SETTLE+3). With defaults this is E0+24.
- Handshake: the transfer occurs on the edge where res_valid & res_ready; res_ready may already be high when res_valid rises.
- DONE lasts ≥1 cycle, so minimum IDLE-to-IDLE is 2 + N·(SETTLE+3) cycles.
- Back-to-back: with start held high, the next burst's launch follows the handshake edge by 2 cycles (one IDLE cycle).
- No combinational path from any input to any output; all outputs are registered.

## Test plan

- Default parameters, therm=32'h000000FF constant, start pulse, res_ready=1: exactly 4 launch pulses and 4 capture pulses. res_valid at E0+24 with result=8, bubble=0, ovf=0, held one cycle.
- Samples of popcount 5, 6, 6, 6 (therm 0x1F, 0x3F, 0x3F, 0x3F): result=5, since 23>>2 truncates.
- One sample therm=32'h000000F5 (popcount 6, non-monotonic), others 0x3F: result=6, bubble=1. The next clean burst returns bubble=0.
- therm=32'hFFFFFFFF for all samples: result=32, ovf=1. therm=0: result=0, ovf=0.
- abort in the second sample's WAIT: no further launch; busy=0 and IDLE at the next edge; res_valid never rises; the previous result is unchanged. A following start produces a correct fresh result.
- Backpressure and reset:
  - Hold res_ready=0 for 10 cycles after res_valid: result and flags stay stable, launch stays low, and abort is ignored.
  - Assert rst mid-WAIT: outputs reach their reset values immediately.
